// File: rtl/ysyx_23060251_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_23060251_pkg
//  Purpose  : Shared types and widths for the ysyx_23060251 core. Holds the
//             AXI read-channel bus widths, the read arbiter's one-hot state
//             encoding and the bus-owner enum.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060251_pkg;

    // Reset is active-high.
    localparam logic RST_ENABLE = 1'b1;

    // AXI read-channel widths
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_RESP_W = 2;

    // Read arbiter state, one-hot
    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_ADDR = 3'b010,
        ARB_DATA = 3'b100
    } arb_state_e;

    // Which master currently owns the downstream read port
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage : ysyx_23060251_pkg
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_rd_arbiter
//  Purpose  : Two-master (IFU, LSU) to one-slave AXI read arbiter. Exactly one
//             read is outstanding at a time: IDLE (arbitrate) -> ADDR (forward
//             AR) -> DATA (forward R) -> IDLE.
//  Params   : RR_EN   0 = LSU has fixed priority over IFU on a tie
//                     1 = round-robin on a tie (master not granted last wins)
//  Ports    : clk_i, rst_i                     clock, sync active-high reset
//             ifu_ar_* / ifu_r_*               IFU read master
//             lsu_ar_* / lsu_r_*               LSU read master
//             slv_ar_* / slv_r_*               downstream read slave
//  Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter
    import ysyx_23060251_pkg::*;
#(
    parameter int RR_EN = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  ifu_ar_valid_i,
    input  logic [AXI_ADDR_W-1:0] ifu_ar_addr_i,
    output logic                  ifu_ar_ready_o,
    output logic                  ifu_r_valid_o,
    output logic [AXI_DATA_W-1:0] ifu_r_data_o,
    output logic [AXI_RESP_W-1:0] ifu_r_resp_o,
    input  logic                  ifu_r_ready_i,

    input  logic                  lsu_ar_valid_i,
    input  logic [AXI_ADDR_W-1:0] lsu_ar_addr_i,
    output logic                  lsu_ar_ready_o,
    output logic                  lsu_r_valid_o,
    output logic [AXI_DATA_W-1:0] lsu_r_data_o,
    output logic [AXI_RESP_W-1:0] lsu_r_resp_o,
    input  logic                  lsu_r_ready_i,

    output logic                  slv_ar_valid_o,
    output logic [AXI_ADDR_W-1:0] slv_ar_addr_o,
    input  logic                  slv_ar_ready_i,
    input  logic                  slv_r_valid_i,
    input  logic [AXI_DATA_W-1:0] slv_r_data_i,
    input  logic [AXI_RESP_W-1:0] slv_r_resp_i,
    output logic                  slv_r_ready_o
);

    arb_state_e state_q;
    arb_owner_e owner_q;
    arb_owner_e last_q;     // master granted most recently (round-robin memory)
    arb_owner_e grant_d;    // owner chosen this cycle if IDLE sees a request

    // Arbitration decision. A lone requester always wins; on a tie LSU wins
    // in fixed-priority mode, otherwise whoever was not granted last.
    function automatic arb_owner_e arb_pick(
        input logic       ifu_req,
        input logic       lsu_req,
        input arb_owner_e last
    );
        arb_owner_e pick;
        pick = OWN_IFU;
        if (lsu_req && !ifu_req) begin
            pick = OWN_LSU;
        end else if (lsu_req && ifu_req) begin
            if (RR_EN != 0) begin
                pick = (last == OWN_LSU) ? OWN_IFU : OWN_LSU;
            end else begin
                pick = OWN_LSU;
            end
        end
        return pick;
    endfunction

    assign grant_d = arb_pick(ifu_ar_valid_i, lsu_ar_valid_i, last_q);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (ifu_ar_valid_i || lsu_ar_valid_i) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        state_q <= ARB_ADDR;
                    end
                end
                ARB_ADDR: begin
                    if (slv_ar_valid_o && slv_ar_ready_i) begin
                        state_q <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (slv_r_valid_i && slv_r_ready_o) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Channel steering. Everything is zero in IDLE; only the owner's
    // handshake signals are connected, and the slave's R channel is only
    // observed in DATA so stray responses are dropped.
    // ------------------------------------------------------------------
    logic own_lsu;
    assign own_lsu = (owner_q == OWN_LSU);

    always_comb begin
        ifu_ar_ready_o = 1'b0;
        lsu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        lsu_r_valid_o  = 1'b0;
        ifu_r_data_o   = '0;
        lsu_r_data_o   = '0;
        ifu_r_resp_o   = '0;
        lsu_r_resp_o   = '0;
        slv_ar_valid_o = 1'b0;
        slv_ar_addr_o  = '0;
        slv_r_ready_o  = 1'b0;

        case (state_q)
            ARB_ADDR: begin
                slv_ar_valid_o = own_lsu ? lsu_ar_valid_i : ifu_ar_valid_i;
                slv_ar_addr_o  = own_lsu ? lsu_ar_addr_i  : ifu_ar_addr_i;
                ifu_ar_ready_o = !own_lsu && slv_ar_ready_i;
                lsu_ar_ready_o =  own_lsu && slv_ar_ready_i;
            end
            ARB_DATA: begin
                slv_r_ready_o  = own_lsu ? lsu_r_ready_i : ifu_r_ready_i;
                ifu_r_valid_o  = !own_lsu && slv_r_valid_i;
                lsu_r_valid_o  =  own_lsu && slv_r_valid_i;
                // Data and response are broadcast; only valid is steered.
                ifu_r_data_o   = slv_r_data_i;
                lsu_r_data_o   = slv_r_data_i;
                ifu_r_resp_o   = slv_r_resp_i;
                lsu_r_resp_o   = slv_r_resp_i;
            end
            default: ;
        endcase
    end

endmodule : axi_rd_arbiter
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_rd_arbiter
//  Purpose  : Directed self-checking bench for axi_rd_arbiter. Two instances
//             (fixed priority and round-robin) share every input; they behave
//             identically except on ties, where the round-robin one is checked.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
    import ysyx_23060251_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;

    logic                  ifu_ar_valid = 1'b0;
    logic [AXI_ADDR_W-1:0] ifu_ar_addr  = '0;
    logic                  ifu_r_ready  = 1'b0;
    logic                  lsu_ar_valid = 1'b0;
    logic [AXI_ADDR_W-1:0] lsu_ar_addr  = '0;
    logic                  lsu_r_ready  = 1'b0;
    logic                  slv_ar_ready = 1'b0;
    logic                  slv_r_valid  = 1'b0;
    logic [AXI_DATA_W-1:0] slv_r_data   = '0;
    logic [AXI_RESP_W-1:0] slv_r_resp   = '0;

    // Outputs: index 0 = fixed priority, index 1 = round robin
    logic                  ifu_ar_ready [2];
    logic                  ifu_r_valid  [2];
    logic [AXI_DATA_W-1:0] ifu_r_data   [2];
    logic [AXI_RESP_W-1:0] ifu_r_resp   [2];
    logic                  lsu_ar_ready [2];
    logic                  lsu_r_valid  [2];
    logic [AXI_DATA_W-1:0] lsu_r_data   [2];
    logic [AXI_RESP_W-1:0] lsu_r_resp   [2];
    logic                  slv_ar_valid [2];
    logic [AXI_ADDR_W-1:0] slv_ar_addr  [2];
    logic                  slv_r_ready  [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_rd_arbiter #(.RR_EN(g)) u_dut (
            .clk_i          (clk),
            .rst_i          (rst),
            .ifu_ar_valid_i (ifu_ar_valid),
            .ifu_ar_addr_i  (ifu_ar_addr),
            .ifu_ar_ready_o (ifu_ar_ready[g]),
            .ifu_r_valid_o  (ifu_r_valid[g]),
            .ifu_r_data_o   (ifu_r_data[g]),
            .ifu_r_resp_o   (ifu_r_resp[g]),
            .ifu_r_ready_i  (ifu_r_ready),
            .lsu_ar_valid_i (lsu_ar_valid),
            .lsu_ar_addr_i  (lsu_ar_addr),
            .lsu_ar_ready_o (lsu_ar_ready[g]),
            .lsu_r_valid_o  (lsu_r_valid[g]),
            .lsu_r_data_o   (lsu_r_data[g]),
            .lsu_r_resp_o   (lsu_r_resp[g]),
            .lsu_r_ready_i  (lsu_r_ready),
            .slv_ar_valid_o (slv_ar_valid[g]),
            .slv_ar_addr_o  (slv_ar_addr[g]),
            .slv_ar_ready_i (slv_ar_ready),
            .slv_r_valid_i  (slv_r_valid),
            .slv_r_data_i   (slv_r_data),
            .slv_r_resp_i   (slv_r_resp),
            .slv_r_ready_o  (slv_r_ready[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Every output of the fixed-priority instance quiet
    task automatic chk_quiet(input string tag);
        chk({tag, ".ifu_ar_ready"}, 64'(ifu_ar_ready[0]), 64'd0);
        chk({tag, ".lsu_ar_ready"}, 64'(lsu_ar_ready[0]), 64'd0);
        chk({tag, ".ifu_r_valid"},  64'(ifu_r_valid[0]),  64'd0);
        chk({tag, ".lsu_r_valid"},  64'(lsu_r_valid[0]),  64'd0);
        chk({tag, ".slv_ar_valid"}, 64'(slv_ar_valid[0]), 64'd0);
        chk({tag, ".slv_ar_addr"},  64'(slv_ar_addr[0]),  64'd0);
        chk({tag, ".slv_r_ready"},  64'(slv_r_ready[0]),  64'd0);
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk_quiet("reset");

        // ---------------- IFU only, zero-latency slave ----------------
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0000;
        slv_ar_ready = 1'b1; ifu_r_ready = 1'b1; lsu_r_ready = 1'b1;
        settle();
        chk("t1.idle_ar_valid", 64'(slv_ar_valid[0]), 64'd0);
        chk("t1.idle_ifu_ar_ready", 64'(ifu_ar_ready[0]), 64'd0);
        tick();                                     // ADDR
        chk("t1.ar_valid", 64'(slv_ar_valid[0]), 64'd1);
        chk("t1.ar_addr",  64'(slv_ar_addr[0]),  64'h8000_0000);
        chk("t1.ifu_ar_ready", 64'(ifu_ar_ready[0]), 64'd1);
        chk("t1.lsu_ar_ready", 64'(lsu_ar_ready[0]), 64'd0);
        tick();                                     // DATA
        ifu_ar_valid = 1'b0; slv_ar_ready = 1'b0;
        slv_r_valid = 1'b1; slv_r_data = 32'h0000_0413; slv_r_resp = 2'b00;
        settle();
        chk("t1.ifu_r_valid", 64'(ifu_r_valid[0]), 64'd1);
        chk("t1.ifu_r_data",  64'(ifu_r_data[0]),  64'h0000_0413);
        chk("t1.lsu_r_valid", 64'(lsu_r_valid[0]), 64'd0);
        chk("t1.slv_r_ready", 64'(slv_r_ready[0]), 64'd1);
        tick();                                     // IDLE
        slv_r_valid = 1'b0;
        settle();
        chk("t1.ifu_r_valid_after", 64'(ifu_r_valid[0]), 64'd0);

        // ---------------- simultaneous, fixed priority ----------------
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0004;
        lsu_ar_valid = 1'b1; lsu_ar_addr = 32'ha000_0000;
        slv_ar_ready = 1'b1;
        settle();
        tick();                                     // ADDR, LSU owner
        chk("t2.first_addr", 64'(slv_ar_addr[0]), 64'ha000_0000);
        chk("t2.lsu_ar_ready", 64'(lsu_ar_ready[0]), 64'd1);
        chk("t2.ifu_ar_ready", 64'(ifu_ar_ready[0]), 64'd0);
        tick();                                     // DATA
        lsu_ar_valid = 1'b0;
        slv_r_valid = 1'b1; slv_r_data = 32'h0000_0011; slv_r_resp = 2'b10;
        settle();
        chk("t2.lsu_r_valid", 64'(lsu_r_valid[0]), 64'd1);
        chk("t2.lsu_r_resp",  64'(lsu_r_resp[0]),  64'd2);
        chk("t2.ifu_r_valid", 64'(ifu_r_valid[0]), 64'd0);
        tick();                                     // IDLE
        slv_r_valid = 1'b0;
        settle();
        chk("t2.idle_ar_valid", 64'(slv_ar_valid[0]), 64'd0);
        tick();                                     // ADDR, IFU owner
        chk("t2.second_addr", 64'(slv_ar_addr[0]), 64'h8000_0004);
        chk("t2.ifu_ar_ready2", 64'(ifu_ar_ready[0]), 64'd1);
        tick();                                     // DATA
        ifu_ar_valid = 1'b0;
        slv_r_valid = 1'b1; slv_r_data = 32'h0000_0022; slv_r_resp = 2'b00;
        settle();
        chk("t2.ifu_r_valid2", 64'(ifu_r_valid[0]), 64'd1);
        chk("t2.ifu_r_data2",  64'(ifu_r_data[0]),  64'h0000_0022);
        tick();                                     // IDLE
        slv_r_valid = 1'b0;
        settle();

        // ---------------- round robin, continuous requests ----------------
        // Slave is always ready and always presents R valid, which also
        // exercises the "R valid ignored outside DATA" rule in IDLE/ADDR.
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_1000;
        lsu_ar_valid = 1'b1; lsu_ar_addr = 32'ha000_1000;
        slv_ar_ready = 1'b1; slv_r_valid = 1'b1; slv_r_data = 32'hcafe_0000;
        settle();
        chk("t3.idle_slv_r_ready", 64'(slv_r_ready[1]), 64'd0);
        chk("t3.idle_lsu_r_valid", 64'(lsu_r_valid[1]), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();                                 // ADDR
            chk($sformatf("t3.rr_addr%0d", i), 64'(slv_ar_addr[1]),
                (i % 2 == 0) ? 64'ha000_1000 : 64'h8000_1000);
            chk($sformatf("t3.fp_addr%0d", i), 64'(slv_ar_addr[0]), 64'ha000_1000);
            chk($sformatf("t3.rr_addr_rvalid%0d", i),
                64'(ifu_r_valid[1] | lsu_r_valid[1]), 64'd0);
            tick();                                 // DATA
            chk($sformatf("t3.rr_lsu_r_valid%0d", i), 64'(lsu_r_valid[1]),
                (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("t3.rr_ifu_r_valid%0d", i), 64'(ifu_r_valid[1]),
                (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();                                 // IDLE
            if (i == 5) begin
                ifu_ar_valid = 1'b0; lsu_ar_valid = 1'b0;
                slv_ar_ready = 1'b0; slv_r_valid = 1'b0;
            end
            settle();
            chk($sformatf("t3.idle_r_ready%0d", i), 64'(slv_r_ready[1]), 64'd0);
        end

        // ---------------- slow slave: AR +3, R +5 ----------------
        tick();                                     // both DUTs idle
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0100;
        settle();
        tick();                                     // ADDR
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t4.ar_valid_wait%0d", k), 64'(slv_ar_valid[0]), 64'd1);
            chk($sformatf("t4.ar_addr_wait%0d", k),  64'(slv_ar_addr[0]),  64'h8000_0100);
            tick();
        end
        slv_ar_ready = 1'b1;
        settle();
        chk("t4.ar_addr_hs", 64'(slv_ar_addr[0]), 64'h8000_0100);
        chk("t4.ifu_ar_ready", 64'(ifu_ar_ready[0]), 64'd1);
        tick();                                     // DATA
        ifu_ar_valid = 1'b0; slv_ar_ready = 1'b0;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4.r_wait%0d", k), 64'(ifu_r_valid[0]), 64'd0);
            tick();
        end
        slv_r_valid = 1'b1; slv_r_data = 32'h1234_5678;
        settle();
        chk("t4.ifu_r_valid", 64'(ifu_r_valid[0]), 64'd1);
        chk("t4.ifu_r_data",  64'(ifu_r_data[0]),  64'h1234_5678);
        tick();                                     // IDLE
        slv_r_valid = 1'b0;
        settle();
        chk("t4.ifu_r_valid_once", 64'(ifu_r_valid[0]), 64'd0);

        // ---------------- reset in DATA ----------------
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0200; slv_ar_ready = 1'b1;
        settle();
        tick();                                     // ADDR
        tick();                                     // DATA
        ifu_ar_valid = 1'b0; slv_ar_ready = 1'b0;
        settle();
        chk("t5.in_data", 64'(slv_r_ready[0]), 64'd1);
        rst = 1'b1;
        tick();                                     // IDLE via reset
        rst = 1'b0;
        settle();
        chk_quiet("t5.after_rst");
        slv_r_valid = 1'b1; slv_r_data = 32'hdead_beef;
        settle();
        chk("t5.stray_ifu_r_valid", 64'(ifu_r_valid[0]), 64'd0);
        chk("t5.stray_r_ready",     64'(slv_r_ready[0]), 64'd0);
        tick();
        chk("t5.stray_ifu_r_valid2", 64'(ifu_r_valid[0]), 64'd0);
        chk("t5.stray_lsu_r_valid2", 64'(lsu_r_valid[0]), 64'd0);
        slv_r_valid = 1'b0;

        // ---------------- owner r_ready back-pressure ----------------
        ifu_ar_valid = 1'b1; ifu_ar_addr = 32'h8000_0300; slv_ar_ready = 1'b1;
        ifu_r_ready = 1'b0;
        settle();
        tick();                                     // ADDR
        tick();                                     // DATA
        ifu_ar_valid = 1'b0; slv_ar_ready = 1'b0;
        slv_r_valid = 1'b1; slv_r_data = 32'h0000_0abc;
        settle();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t6.r_ready_hold%0d", k), 64'(slv_r_ready[0]), 64'd0);
            chk($sformatf("t6.r_valid_hold%0d", k), 64'(ifu_r_valid[0]), 64'd1);
            tick();
        end
        ifu_r_ready = 1'b1;
        settle();
        chk("t6.r_ready_release", 64'(slv_r_ready[0]), 64'd1);
        tick();                                     // IDLE
        slv_r_valid = 1'b0;
        settle();
        chk("t6.done_r_valid", 64'(ifu_r_valid[0]), 64'd0);
        chk("t6.done_r_ready", 64'(slv_r_ready[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_axi_rd_arbiter
`default_nettype wire

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 0, meaning 0 = fixed priority LSU over IFU and 1 = round-robin on simultaneous requests.
REQ-002 SHALL have clk_i  input  1  meaning the single clock; all logic is on posedge clk_i.
REQ-003 SHALL have rst_i  input  1  meaning reset, synchronous and active-high (`ysyx_23060251_rst_enable).
REQ-004 SHALL have ifu_ar_valid_i  input  1  meaning IFU read-address valid.
REQ-005 SHALL have ifu_ar_addr_i  input  `ysyx_23060251_axi_addr_bus  meaning IFU fetch address.
REQ-006 SHALL have ifu_ar_ready_o  output  1  meaning IFU read-address ready.
REQ-007 SHALL have ifu_r_valid_o  output  1  meaning IFU read-data valid.
REQ-008 SHALL have ifu_r_data_o  output  `ysyx_23060251_axi_data_bus  meaning IFU read data.
REQ-009 SHALL have ifu_r_resp_o  output  2  meaning IFU read response.
REQ-010 SHALL have ifu_r_ready_i  input  1  meaning IFU read-data ready.
REQ-011 SHALL have lsu_ar_valid_i, lsu_ar_addr_i, lsu_ar_ready_o, lsu_r_valid_o, lsu_r_data_o, lsu_r_resp_o and lsu_r_ready_i, each with the same direction, width and meaning as REQ-004..010, for the LSU.
REQ-012 SHALL have slv_ar_valid_o  output  1  meaning downstream read-address valid.
REQ-013 SHALL have slv_ar_addr_o  output  `ysyx_23060251_axi_addr_bus  meaning downstream read address.
REQ-014 SHALL have slv_ar_ready_i  input  1  meaning downstream read-address ready.
REQ-015 SHALL have slv_r_valid_i  input  1  meaning downstream read-data valid.
REQ-016 SHALL have slv_r_data_i  input  `ysyx_23060251_axi_data_bus  meaning downstream read data.
REQ-017 SHALL have slv_r_resp_i  input  2  meaning downstream read response.
REQ-018 SHALL have slv_r_ready_o  output  1  meaning downstream read-data ready.

Function
REQ-019 SHALL implement one-hot states IDLE, ADDR, DATA, and a registered owner (IFU/LSU); exactly one transaction is outstanding at a time.
REQ-020 In IDLE, with any ar_valid high, the block SHALL latch the owner and go to ADDR next cycle; all ready/valid outputs are 0 in IDLE, giving one cycle of arbitration latency.
REQ-021 Arbitration, RR_EN=0: LSU wins when both request; RR_EN=1: on a tie the master not granted last wins, while a single requester always wins.
REQ-022 In ADDR, slv_ar_valid_o/slv_ar_addr_o SHALL equal the owner's inputs, the owner's ar_ready SHALL equal slv_ar_ready_i, and the non-owner's ar_ready SHALL be 0; an ar handshake moves the block to DATA.
REQ-023 In DATA, slv_r_ready_o SHALL equal the owner's r_ready and the owner's r_valid SHALL equal slv_r_valid_i, with the non-owner's r_valid at 0; an r handshake moves the block to IDLE.
REQ-024 r_data/r_resp MAY be broadcast to both masters; only r_valid is gated.
REQ-025 slv_r_valid_i outside DATA SHALL be ignored, with slv_r_ready_o held at 0.
REQ-026 A non-owner request SHALL wait and be granted at the IDLE that follows the owner's r handshake, with no starvation when RR_EN=1.
REQ-027 A back-to-back request cycle is IDLE, ADDR, DATA, IDLE, so the minimum is 3 cycles per read at zero slave latency.

Reset
REQ-028 On rst_i high, the state SHALL become IDLE, owner IFU, last-grant IFU, with all outputs 0 in the following cycle; reset mid-ADDR/DATA SHALL abandon the transaction without emitting a response.

Structure
REQ-029 State encodings and the owner enum SHALL be placed in the shared ysyx_23060251 defines/package; bus widths come from the existing axi_addr/axi_data macros.
REQ-030 SHALL be a single module with no sub-modules; the arbitration decision is an internal function.

Verification
REQ-031 IFU only: ifu_ar addr 0x8000_0000, slave ready same cycle, r data 0x0000_0413 one cycle later -> ifu_r_valid_o for 1 cycle with 0x0000_0413, and lsu_r_valid_o stays 0.
REQ-032 Simultaneous IFU 0x8000_0004 / LSU 0xa000_0000 with RR_EN=0 -> LSU address is forwarded first and the IFU address follows after the LSU r handshake.
REQ-033 RR_EN=1, both masters requesting continuously for 6 reads -> grants alternate LSU, IFU, LSU, ...
REQ-034 Slave ar_ready delayed 3 cycles and r_valid delayed 5 cycles -> slv_ar_valid_o and the address are stable throughout, and the owner receives exactly one r_valid.
REQ-035 rst_i asserted in DATA -> IDLE on the next cycle, and a stray slv_r_valid_i afterwards produces no master r_valid.
REQ-036 Owner r_ready held low for 4 cycles while slv_r_valid_i is high -> the block stays in DATA with slv_r_ready_o at 0, then completes.
